// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute-stage sequencer.
//   - ALU operation codes driven onto alu_op
//   - sequencer FSM state type
//   - EX/MEM output entry layout
//   - default divider watchdog limit
package ex_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00010;
    localparam logic [4:0] ALU_DIV = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b00101;
    localparam logic [4:0] ALU_XOR = 5'b00110;
    localparam logic [4:0] ALU_SLL = 5'b00111;
    localparam logic [4:0] ALU_SRL = 5'b01000;
    localparam logic [4:0] ALU_SRA = 5'b01001;
    localparam logic [4:0] ALU_EQ  = 5'b01010;
    localparam logic [4:0] ALU_LT  = 5'b01011;

    localparam int DIV_TIMEOUT_DEF = 40;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIV_START,
        DIV_WAIT
    } ex_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] hi;
        logic [4:0]  rd;
        logic        zero;
        logic        overflow;
        logic        err;
    } ex_out_t;

endpackage

// File: rtl/ex_out_reg.sv
// ex_out_reg: EX/MEM output register with valid/ready handshake.
//   clk, rst_n   : clock, async active-low reset
//   flush        : drops the held entry (valid cleared, data kept)
//   wr_en        : load wr_data this cycle
//   wr_data      : entry to capture
//   out_ready    : downstream consumes the entry
//   out_valid    : entry valid
//   out_data     : held entry
module ex_out_reg
    import ex_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    wr_en,
    input  ex_out_t wr_data,
    input  logic    out_ready,
    output logic    out_valid,
    output ex_out_t out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // Write beats drain, so a simultaneous drain+write keeps valid high
            // with the new entry in place.
            if (flush)
                out_valid <= 1'b0;
            else if (wr_en)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (wr_en && !flush)
                out_data <= wr_data;
        end
    end

endmodule

// File: rtl/ex_alu_sequencer.sv
// ex_alu_sequencer: execute-stage sequencer in front of the 32-bit ALU.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : kills the in-flight op and the output entry
//   in_valid/in_ready     : op handshake from ID/EX
//   in_op/in_a/in_b/in_rd : decoded op, operands, destination tag
//   alu_a/alu_b/alu_op    : operands/op held stable for the ALU
//   alu_start_div         : one-cycle divider start pulse
//   alu_result/alu_ext    : ALU result and extended (hi:lo) result
//   alu_zero/alu_overflow : ALU flags
//   alu_div_ready         : divider done level
//   out_*                 : EX/MEM entry with valid/ready handshake
//   out_err               : divider watchdog expired, result forced to 0
// in_ready depends combinationally on out_ready (an EXEC op can retire and a
// new one enter in the same cycle). No path exists from in_valid to out_*.
module ex_alu_sequencer
    import ex_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic        alu_start_div,
    input  logic [31:0] alu_result,
    input  logic [63:0] alu_ext,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_div_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_hi,
    output logic [4:0]  out_rd,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_err
);

    localparam int             CW      = $clog2(DIV_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_TIMEOUT - 1);

    ex_state_t   state, state_nxt, launch_state;
    logic [CW-1:0] wd_cnt;
    logic [4:0]  op_q, rd_q;
    logic [31:0] a_q, b_q;
    logic        accept, can_produce, out_write, div_by_zero, wd_expired;
    ex_out_t     wr_data, out_q;
    logic        unused_ext_lo;

    assign unused_ext_lo = ^alu_ext[31:0];

    assign div_by_zero   = (op_q == ALU_DIV) && (b_q == 32'd0);
    assign wd_expired    = (wd_cnt == CNT_MAX);
    assign alu_start_div = (state == DIV_START) && !flush;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;

    // Only a non-zero divide goes to the divider; divide-by-zero is resolved
    // in EXEC without starting it.
    assign launch_state = ((in_op == ALU_DIV) && (in_b != 32'd0)) ? DIV_START : EXEC;

    always_comb begin
        can_produce = 1'b0;
        case (state)
            EXEC:     can_produce = 1'b1;
            DIV_WAIT: can_produce = alu_div_ready || wd_expired;
            default:  can_produce = 1'b0;
        endcase

        out_write = can_produce && (!out_valid || out_ready) && !flush;
        in_ready  = !flush && ((state == IDLE) || ((state == EXEC) && out_write));
        accept    = in_valid && in_ready;

        wr_data          = '0;
        wr_data.result   = alu_result;
        wr_data.hi       = alu_ext[63:32];
        wr_data.rd       = rd_q;
        wr_data.zero     = alu_zero;
        wr_data.overflow = alu_overflow;
        if ((state == EXEC) && div_by_zero) begin
            wr_data.result   = 32'hFFFF_FFFF;
            wr_data.hi       = a_q;
            wr_data.zero     = 1'b0;
            wr_data.overflow = 1'b0;
        end else if ((state == DIV_WAIT) && !alu_div_ready) begin
            // Only reachable through the watchdog: ready wins when both hold.
            wr_data.result   = 32'd0;
            wr_data.hi       = 32'd0;
            wr_data.zero     = 1'b1;
            wr_data.overflow = 1'b0;
            wr_data.err      = 1'b1;
        end

        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = launch_state;
            EXEC:      if (out_write) state_nxt = accept ? launch_state : IDLE;
            DIV_START: state_nxt = DIV_WAIT;
            DIV_WAIT:  if (out_write) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= in_op;
                a_q  <= in_a;
                b_q  <= in_b;
                rd_q <= in_rd;
            end
        end
    end

    // Watchdog: counts DIV_WAIT cycles, freezes while a ready result waits
    // for the output register, saturates at the limit until written out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == DIV_START)
            wd_cnt <= '0;
        else if ((state == DIV_WAIT) && !alu_div_ready && !wd_expired)
            wd_cnt <= wd_cnt + 1'b1;
    end

    ex_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (out_write),
        .wr_data   (wr_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_q)
    );

    assign out_result   = out_q.result;
    assign out_hi       = out_q.hi;
    assign out_rd       = out_q.rd;
    assign out_zero     = out_q.zero;
    assign out_overflow = out_q.overflow;
    assign out_err      = out_q.err;

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Testbench for ex_alu_sequencer: directed ops with hand-computed results,
// scoreboard queue filled at accept time and drained by a monitor on each
// output handshake.
module tb_ex_alu_sequencer;
    import ex_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [4:0]  rd;
        logic        z;
        logic        ov;
        logic        err;
    } exp_t;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready;
    logic [4:0]  in_op, in_rd;
    logic [31:0] in_a, in_b;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic        alu_start_div;
    logic [31:0] alu_result;
    logic [63:0] alu_ext;
    logic        alu_zero, alu_overflow, alu_div_ready;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_hi;
    logic [4:0]  out_rd;
    logic        out_zero, out_overflow, out_err;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   div_delay = 0;
    int   div_cnt;
    exp_t sb[$];

    ex_alu_sequencer #(.DIV_TIMEOUT(40)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start_div(alu_start_div),
        .alu_result(alu_result), .alu_ext(alu_ext), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_div_ready(alu_div_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_hi(out_hi), .out_rd(out_rd), .out_zero(out_zero),
        .out_overflow(out_overflow), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU (ADD/SUB/DIV only); divide results appear at once but the
    // done level follows the divider delay model below.
    always_comb begin
        logic [31:0] r, h;
        r = 32'd0;
        h = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                r = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (r[31] != alu_a[31]);
            end
            ALU_SUB: begin
                r = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (r[31] != alu_a[31]);
            end
            ALU_DIV: if (alu_b != 32'd0) begin
                r = alu_a / alu_b;
                h = alu_a % alu_b;
            end
            default: r = 32'd0;
        endcase
        alu_result = r;
        alu_ext    = {h, r};
        alu_zero   = (r == 32'd0);
    end

    // Divider done level: rises div_delay cycles after the start edge,
    // never when div_delay is 0, cleared by the next start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_div_ready <= 1'b0;
            div_cnt       <= 0;
        end else if (alu_start_div) begin
            alu_div_ready <= 1'b0;
            div_cnt       <= div_delay;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) alu_div_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (alu_start_div) pulses++;
    end

    // Monitor: every output handshake pops and compares one expected entry.
    always @(negedge clk) begin
        exp_t act, e;
        #2;
        if (rst_n && out_valid && out_ready) begin
            act = {out_result, out_hi, out_rd, out_zero, out_overflow, out_err};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_entry: unexpected entry %h, none expected", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_entry rd=%0d: got res=%h hi=%h z=%b ov=%b err=%b, want res=%h hi=%h rd=%0d z=%b ov=%b err=%b",
                             out_rd, act.res, act.hi, act.z, act.ov, act.err,
                             e.res, e.hi, e.rd, e.z, e.ov, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drives one op from a negedge, waits (bounded) for acceptance, returns
    // at the negedge after the accepting edge with in_valid still high.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input exp_t e, input bit push, output int waited);
        in_valid = 1'b1;
        in_op = op; in_a = a; in_b = b; in_rd = rd;
        waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d not accepted, in_ready=%b want 1", op, in_ready);
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts cycles until out_valid rises; also counts cycles in_ready was high.
    task automatic wait_out(output int n, output int acc);
        n = 0; acc = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk); #1;
            n++;
            if (in_ready && !out_valid) acc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, n, acc, p0, cnt;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Reset state
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_outs_zero", int'({out_result, out_hi, out_rd, out_err} != 0), 0);
        chk("reset_alu_zero", int'({alu_a, alu_b, alu_op, alu_start_div} != 0), 0);

        // ADD back-to-back, second op accepted with the first retiring
        @(negedge clk);
        send(ALU_ADD, 32'd5, 32'd7, 5'd1, exp_t'({32'd12, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0}), 1'b1, w);
        send(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd2,
             exp_t'({32'h8000_0000, 32'd0, 5'd2, 1'b0, 1'b1, 1'b0}), 1'b1, w);
        chk("b2b_accept_wait", w, 0);
        in_valid = 1'b0;
        #1;
        chk("add_latency_out_valid", int'(out_valid), 1);
        repeat (2) @(negedge clk);

        // DIV 100/7 with 33-cycle divider
        div_delay = 33;
        p0 = pulses;
        send(ALU_DIV, 32'd100, 32'd7, 5'd3, exp_t'({32'd14, 32'd2, 5'd3, 1'b0, 1'b0, 1'b0}), 1'b1, w);
        in_valid = 1'b0;
        #1;
        chk("div_pulse_cycle", int'(alu_start_div), 1);
        wait_out(n, acc);
        chk("div_latency", n, 35);
        chk("div_no_accept", acc, 0);
        @(negedge clk); #3;
        chk("div_pulse_count", pulses - p0, 1);

        // Divide by zero: no divider, one-cycle latency
        p0 = pulses;
        send(ALU_DIV, 32'h1234, 32'd0, 5'd4,
             exp_t'({32'hFFFF_FFFF, 32'h1234, 5'd4, 1'b0, 1'b0, 1'b0}), 1'b1, w);
        in_valid = 1'b0;
        #1;
        chk("dbz_no_start", int'(alu_start_div), 0);
        @(negedge clk); #1;
        chk("dbz_latency_out_valid", int'(out_valid), 1);
        @(negedge clk); #3;
        chk("dbz_pulse_count", pulses - p0, 0);

        // Output stall: two ops held, no third accept, nothing lost
        out_ready = 1'b0;
        send(ALU_SUB, 32'd3, 32'd3, 5'd5, exp_t'({32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0}), 1'b1, w);
        send(ALU_ADD, 32'd1, 32'd2, 5'd6, exp_t'({32'd3, 32'd0, 5'd6, 1'b0, 1'b0, 1'b0}), 1'b1, w);
        chk("stall_second_accept_wait", w, 0);
        in_valid = 1'b0;
        cnt = 0;
        repeat (4) begin
            #1;
            if (!out_valid || in_ready) cnt++;
            @(negedge clk);
        end
        chk("stall_hold_cycles_bad", cnt, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Divider never ready: watchdog abort
        div_delay = 0;
        send(ALU_DIV, 32'd9, 32'd3, 5'd7, exp_t'({32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1}), 1'b1, w);
        in_valid = 1'b0;
        #1;
        wait_out(n, acc);
        chk("timeout_latency", n, 41);
        @(negedge clk);

        // Flush during DIV_WAIT: no entry, late ready ignored
        div_delay = 10;
        p0 = pulses;
        send(ALU_DIV, 32'd50, 32'd5, 5'd8, '0, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", int'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_to_idle_in_ready", int'(in_ready), 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("flush_no_output", cnt, 0);
        chk("flush_pulse_count", pulses - p0, 1);

        // Reset during DIV_WAIT
        send(ALU_DIV, 32'd77, 32'd7, 5'd9, '0, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_alu_cleared", int'({alu_a, alu_b, alu_op} != 0), 0);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", int'(in_ready), 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("rst_no_output", cnt, 0);

        // Recovery op
        @(negedge clk);
        send(ALU_ADD, 32'd10, 32'd20, 5'd10, exp_t'({32'd30, 32'd0, 5'd10, 1'b0, 1'b0, 1'b0}), 1'b1, w);
        in_valid = 1'b0;
        cnt = 0;
        while (sb.size() != 0 && cnt < 20) begin
            @(negedge clk); #3;
            cnt++;
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
